serdes_strobe_serializer: RTL and testbench

SERDES_STROBE_SERIALIZER -- requirements
Module: serdes_strobe_serializer

---
 rtl/serdes_strobe_serializer_pkg.sv | 14 +
 rtl/serdes_strobe_serializer_checker.sv | 51 +++++
 rtl/serdes_strobe_serializer.sv | 97 +++++++++
 tb/tb_serdes_strobe_serializer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_strobe_serializer_pkg.sv
// Shared constants for the strobe-loaded serializer: legal word widths,
// default idle/training words and the word-counter width.
package serdes_strobe_serializer_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 8;
    localparam int CNT_W     = 16;
    // Wide enough to count strobe spacings up to WIDTH_MAX.
    localparam int SPACE_W   = 4;

    localparam logic [WIDTH_MAX-1:0] DEFAULT_IDLE_WORD  = 8'h00;
    localparam logic [WIDTH_MAX-1:0] DEFAULT_TRAIN_WORD = 8'h55;

endpackage

// File: rtl/serdes_strobe_serializer_checker.sv
// Strobe-spacing checker: flags strobes not exactly WIDTH cycles apart and
// missing strobes, re-arming on the next strobe after a timeout.
module serdes_strobe_checker
    import serdes_strobe_serializer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic STROBE,
    output logic STROBE_ERR
);

    logic               armed_q, armed_d;
    logic [SPACE_W-1:0] since_q, since_d;
    logic               err_q, err_d;

    always_comb begin
        armed_d = armed_q;
        since_d = since_q;
        err_d   = 1'b0;
        if (STROBE) begin
            err_d   = armed_q && (since_q != SPACE_W'(WIDTH));
            armed_d = 1'b1;
            since_d = SPACE_W'(1);
        end else if (armed_q) begin
            // A full word period with no strobe: report once, then wait to resync.
            if (since_q == SPACE_W'(WIDTH)) begin
                err_d   = 1'b1;
                armed_d = 1'b0;
            end else begin
                since_d = since_q + SPACE_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            armed_q <= 1'b0;
            since_q <= '0;
            err_q   <= 1'b0;
        end else begin
            armed_q <= armed_d;
            since_q <= since_d;
            err_q   <= err_d;
        end
    end

    assign STROBE_ERR = err_q;

endmodule

// File: rtl/serdes_strobe_serializer.sv
// Strobe-loaded parallel-to-serial converter with a one-deep hold register.
// Define SERDES_STROBE_SERIALIZER_TRAIN_EN to send TRAIN_WORD instead of IDLE_WORD on idle loads.
module serdes_strobe_serializer
    import serdes_strobe_serializer_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] IDLE_WORD  = DEFAULT_IDLE_WORD[WIDTH-1:0],
    parameter logic [WIDTH-1:0] TRAIN_WORD = DEFAULT_TRAIN_WORD[WIDTH-1:0]
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             STROBE,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             DOUT,
    output logic             UNDERFLOW,
    output logic             STROBE_ERR,
    output logic [CNT_W-1:0] WORD_CNT
);

`ifdef SERDES_STROBE_SERIALIZER_TRAIN_EN
    localparam logic [WIDTH-1:0] IDLE_LOAD = TRAIN_WORD;
`else
    localparam logic [WIDTH-1:0] IDLE_LOAD = IDLE_WORD;
`endif

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_word_q, hold_word_d;
    logic             hold_valid_q, hold_valid_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             seen_data_q, seen_data_d;
    logic             underflow_q, underflow_d;
    logic             accept;

    // The hold slot frees up in the same cycle a strobe consumes it.
    assign DIN_READY = (!hold_valid_q || STROBE) && !RST;
    assign accept    = DIN_VALID && DIN_READY;

    always_comb begin
        shift_d      = shift_q;
        hold_word_d  = hold_word_q;
        hold_valid_d = hold_valid_q;
        word_cnt_d   = word_cnt_q;
        seen_data_d  = seen_data_q;
        underflow_d  = 1'b0;
        if (STROBE) begin
            if (hold_valid_q) begin
                shift_d      = hold_word_q;
                hold_valid_d = 1'b0;
                word_cnt_d   = word_cnt_q + CNT_W'(1);
                seen_data_d  = 1'b1;
            end else begin
                shift_d     = IDLE_LOAD;
                underflow_d = seen_data_q;
            end
        end else begin
            shift_d = shift_q >> 1;
        end
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_word_d  = DIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_q      <= '0;
            hold_word_q  <= '0;
            hold_valid_q <= 1'b0;
            word_cnt_q   <= '0;
            seen_data_q  <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            hold_word_q  <= hold_word_d;
            hold_valid_q <= hold_valid_d;
            word_cnt_q   <= word_cnt_d;
            seen_data_q  <= seen_data_d;
            underflow_q  <= underflow_d;
        end
    end

    serdes_strobe_checker #(
        .WIDTH (WIDTH)
    ) u_checker (
        .CLK        (CLK),
        .RST        (RST),
        .STROBE     (STROBE),
        .STROBE_ERR (STROBE_ERR)
    );

    assign DOUT      = shift_q[0];
    assign UNDERFLOW = underflow_q;
    assign WORD_CNT  = word_cnt_q;

endmodule

// File: tb/tb_serdes_strobe_serializer.sv
// Self-checking bench for serdes_strobe_serializer (WIDTH=4): vector table,
// directed corner sequences and randomized traffic against a word-level model.
module tb_serdes_strobe_serializer;

    localparam int W = 4;
`ifdef SERDES_STROBE_SERIALIZER_TRAIN_EN
    localparam logic [W-1:0] IDLE_EXP = 4'b0101;
`else
    localparam logic [W-1:0] IDLE_EXP = 4'b0000;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          STROBE = 1'b0;
    logic [W-1:0]  DIN = '0;
    logic          DIN_VALID = 1'b0;
    logic          DIN_READY;
    logic          DOUT;
    logic          UNDERFLOW;
    logic          STROBE_ERR;
    logic [15:0]   WORD_CNT;

    int checks = 0;
    int errors = 0;

    serdes_strobe_serializer #(
        .WIDTH (W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .STROBE     (STROBE),
        .DIN        (DIN),
        .DIN_VALID  (DIN_VALID),
        .DIN_READY  (DIN_READY),
        .DOUT       (DOUT),
        .UNDERFLOW  (UNDERFLOW),
        .STROBE_ERR (STROBE_ERR),
        .WORD_CNT   (WORD_CNT)
    );

    always #5 CLK = ~CLK;

    // Word-level reference: a pending-word queue, the word on the wire with the
    // number of cycles since it was loaded, and strobe times in absolute cycles.
    logic [W-1:0] pend_q[$];
    logic [W-1:0] cur_word;
    int           bit_age;
    bit           started;
    int           m_cnt;
    int           cycle;
    int           last_strobe;
    bit           armed;
    bit           m_uf;
    bit           m_err;
    logic         ready_seen;

    function automatic logic model_dout();
        return (bit_age < W) ? cur_word[bit_age] : 1'b0;
    endfunction

    function automatic logic model_ready();
        return (pend_q.size() == 0 || STROBE) && !RST;
    endfunction

    task automatic model_edge();
        logic acc;
        cycle++;
        if (RST) begin
            pend_q.delete();
            cur_word = '0; bit_age = 0; started = 0; m_cnt = 0;
            armed = 0; m_uf = 0; m_err = 0;
            return;
        end
        acc = DIN_VALID && model_ready();
        m_uf = 0;
        m_err = 0;
        if (STROBE) begin
            if (pend_q.size() != 0) begin
                cur_word = pend_q.pop_front();
                m_cnt = (m_cnt + 1) % 65536;
                started = 1;
            end else begin
                cur_word = IDLE_EXP;
                m_uf = started;
            end
            bit_age = 0;
            m_err = armed && (cycle - last_strobe != W);
            armed = 1;
            last_strobe = cycle;
        end else begin
            if (bit_age < 100) bit_age++;
            if (armed && (cycle - last_strobe == W)) begin
                m_err = 1;
                armed = 0;
            end
        end
        if (acc) pend_q.push_back(DIN);
    endtask

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock cycle with the inputs already driven; checks every output against the model.
    task automatic apply_stimulus();
        #1;
        ready_seen = DIN_READY;
        check_output("din_ready", {15'd0, DIN_READY}, {15'd0, model_ready()});
        @(posedge CLK);
        model_edge();
        #1;
        check_output("dout", {15'd0, DOUT}, {15'd0, model_dout()});
        check_output("underflow", {15'd0, UNDERFLOW}, {15'd0, m_uf});
        check_output("strobe_err", {15'd0, STROBE_ERR}, {15'd0, m_err});
        check_output("word_cnt", WORD_CNT, 16'(m_cnt));
    endtask

    task automatic tick_unchecked();
        #1;
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic rst, input logic stb, input logic vld, input logic [W-1:0] d);
        RST = rst; STROBE = stb; DIN_VALID = vld; DIN = d;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, '0);
        apply_stimulus();
        apply_stimulus();
        drive(0, 0, 0, '0);
    endtask

    typedef struct {
        logic         rst;
        logic         strobe;
        logic         valid;
        logic [W-1:0] din;
        logic         exp_ready;
        logic         exp_dout;
        logic         exp_uf;
        logic         exp_err;
        logic [15:0]  exp_cnt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [7:0] seq;
        int         err_pulses;
        int         err_at;
        int         offs[5];
        int         phase;

        // Word 0xA loaded, then an idle load, then a missing strobe.
        vecs[0]  = '{1, 0, 0, 4'h0, 0, 0, 0, 0, 16'd0};
        vecs[1]  = '{1, 0, 0, 4'h0, 0, 0, 0, 0, 16'd0};
        vecs[2]  = '{0, 0, 1, 4'hA, 1, 0, 0, 0, 16'd0};
        vecs[3]  = '{0, 1, 0, 4'h0, 1, 0, 0, 0, 16'd1};
        vecs[4]  = '{0, 0, 0, 4'h0, 1, 1, 0, 0, 16'd1};
        vecs[5]  = '{0, 0, 0, 4'h0, 1, 0, 0, 0, 16'd1};
        vecs[6]  = '{0, 0, 0, 4'h0, 1, 1, 0, 0, 16'd1};
        vecs[7]  = '{0, 1, 0, 4'h0, 1, IDLE_EXP[0], 1, 0, 16'd1};
        vecs[8]  = '{0, 0, 0, 4'h0, 1, IDLE_EXP[1], 0, 0, 16'd1};
        vecs[9]  = '{0, 0, 0, 4'h0, 1, IDLE_EXP[2], 0, 0, 16'd1};
        vecs[10] = '{0, 0, 0, 4'h0, 1, IDLE_EXP[3], 0, 0, 16'd1};
        vecs[11] = '{0, 0, 0, 4'h0, 1, 0, 0, 1, 16'd1};

        cycle = 0; last_strobe = 0; armed = 0; started = 0; m_cnt = 0;
        cur_word = '0; bit_age = 0; m_uf = 0; m_err = 0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst, vecs[i].strobe, vecs[i].valid, vecs[i].din);
            apply_stimulus();
            check_output($sformatf("vec%0d_ready", i), {15'd0, ready_seen}, {15'd0, vecs[i].exp_ready});
            check_output($sformatf("vec%0d_dout", i), {15'd0, DOUT}, {15'd0, vecs[i].exp_dout});
            check_output($sformatf("vec%0d_uf", i), {15'd0, UNDERFLOW}, {15'd0, vecs[i].exp_uf});
            check_output($sformatf("vec%0d_err", i), {15'd0, STROBE_ERR}, {15'd0, vecs[i].exp_err});
            check_output($sformatf("vec%0d_cnt", i), WORD_CNT, vecs[i].exp_cnt);
        end

        // Back-to-back words 0x3 then 0xC: second accept rides on the first strobe.
        do_reset();
        drive(0, 0, 1, 4'h3);
        apply_stimulus();
        drive(0, 0, 1, 4'hC);
        apply_stimulus();
        check_output("b2b_ready_full", {15'd0, ready_seen}, 16'd0);
        seq = '0;
        for (int i = 0; i < 8; i++) begin
            drive(0, (i % 4) == 0, i == 0, 4'hC);
            apply_stimulus();
            if (i == 0) check_output("b2b_ready_strobe", {15'd0, ready_seen}, 16'd1);
            seq[i] = DOUT;
        end
        check_output("b2b_stream", {8'd0, seq}, 16'h00C3);
        check_output("b2b_cnt", WORD_CNT, 16'd2);

        // Strobe spacings 4,4,3,4: one error, on the short gap.
        do_reset();
        offs = '{0, 4, 8, 11, 15};
        err_pulses = 0;
        err_at = -1;
        for (int c = 0; c <= 16; c++) begin
            logic stb;
            stb = 0;
            for (int k = 0; k < 5; k++) if (offs[k] == c) stb = 1;
            drive(0, stb, 0, '0);
            apply_stimulus();
            if (STROBE_ERR) begin
                err_pulses++;
                err_at = c;
            end
        end
        check_output("spacing_pulses", 16'(err_pulses), 16'd1);
        check_output("spacing_at", 16'(err_at), 16'd11);

        // Reset two cycles into a word discards it.
        do_reset();
        drive(0, 0, 1, 4'hF);
        apply_stimulus();
        drive(0, 1, 0, '0);
        apply_stimulus();
        drive(0, 0, 0, '0);
        apply_stimulus();
        apply_stimulus();
        check_output("mid_dout_before", {15'd0, DOUT}, 16'd1);
        drive(1, 0, 1, 4'h5);
        apply_stimulus();
        check_output("mid_ready_rst", {15'd0, ready_seen}, 16'd0);
        check_output("mid_dout", {15'd0, DOUT}, 16'd0);
        check_output("mid_cnt", WORD_CNT, 16'd0);
        drive(0, 0, 0, '0);
        apply_stimulus();
        check_output("mid_ready_after", {15'd0, ready_seen}, 16'd1);

        // Counter wrap: load on every cycle.
        do_reset();
        drive(0, 0, 1, 4'h9);
        apply_stimulus();
        for (int i = 0; i < 65535; i++) begin
            drive(0, 1, 1, 4'(i));
            tick_unchecked();
        end
        check_output("wrap_preset", WORD_CNT, 16'hFFFF);
        drive(0, 1, 1, 4'h6);
        apply_stimulus();
        check_output("wrap_zero", WORD_CNT, 16'h0000);

        // Randomized traffic with occasional strobe jitter and resets.
        do_reset();
        phase = 0;
        for (int i = 0; i < 3000; i++) begin
            logic stb;
            stb = (phase == 0);
            if ($urandom_range(0, 19) == 0) stb = ~stb;
            phase = stb ? 1 : (phase + 1) % W;
            drive($urandom_range(0, 199) == 0, stb, $urandom_range(0, 9) < 6, 4'($urandom));
            apply_stimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
